// File: rtl/audio_out_serializer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | audio_out_serializer_if : codec strobes, sample writes, serial output   |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface audio_out_serializer_if #(
  parameter int AUDIO_DATA_WIDTH = 32
);
  logic                        bit_clk_rising_edge;
  logic                        bit_clk_falling_edge;
  logic                        left_right_clk_rising_edge;
  logic                        left_right_clk_falling_edge;
  logic                        enable_audio_output;
  logic [AUDIO_DATA_WIDTH:1]   left_channel_data;
  logic [AUDIO_DATA_WIDTH:1]   right_channel_data;
  logic                        left_channel_data_en;
  logic                        right_channel_data_en;
  logic [7:0]                  left_channel_fifo_write_space;
  logic [7:0]                  right_channel_fifo_write_space;
  logic                        serial_audio_out_data;

  modport master (
    output bit_clk_rising_edge, bit_clk_falling_edge,
    output left_right_clk_rising_edge, left_right_clk_falling_edge,
    output enable_audio_output,
    output left_channel_data, right_channel_data,
    output left_channel_data_en, right_channel_data_en,
    input  left_channel_fifo_write_space, right_channel_fifo_write_space,
    input  serial_audio_out_data
  );

  modport slave (
    input  bit_clk_rising_edge, bit_clk_falling_edge,
    input  left_right_clk_rising_edge, left_right_clk_falling_edge,
    input  enable_audio_output,
    input  left_channel_data, right_channel_data,
    input  left_channel_data_en, right_channel_data_en,
    output left_channel_fifo_write_space, right_channel_fifo_write_space,
    output serial_audio_out_data
  );
endinterface
`default_nettype wire

// File: rtl/audio_out_serializer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | audio_out_serializer : two 128-word sample FIFOs feeding an I2S-style   |
// | MSB-first serializer. Rev 1.0                                           |
// +-------------------------------------------------------------------------+
module audio_out_serializer #(
  parameter int         AUDIO_DATA_WIDTH = 32,
  parameter logic [4:0] BIT_COUNTER_INIT = 5'd31
) (
  input  logic                   clk,
  input  logic                   reset,
  audio_out_serializer_if.slave  bus
);

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      clear;
  logic                      load_frame;
  logic                      load_hold;
  logic                      shift_step;
  logic                      pop;

  logic [AUDIO_DATA_WIDTH:1] rd_data [2];
  logic                      empty   [2];
  logic [7:0]                space   [2];

  logic [AUDIO_DATA_WIDTH:1] shift_reg;
  logic [AUDIO_DATA_WIDTH:1] hold_reg;
  logic [4:0]                bit_cnt;
  logic                      bit_active;
  logic                      serial_out;
  logic                      unused_bit_clk_rise;

  assign unused_bit_clk_rise = bus.bit_clk_rising_edge;

  // A pair is consumed only when both channels have a word, keeping L/R aligned.
  assign pop = load_frame && !empty[0] && !empty[1];

  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic [AUDIO_DATA_WIDTH:1] mem [128];
    logic [AUDIO_DATA_WIDTH:1] wdata;
    logic                      wen;
    logic [6:0]                wr_ptr;
    logic [6:0]                rd_ptr;
    logic                      full;
    logic                      do_wr;
    logic [7:0]                used;
    logic [7:0]                space_q;

    assign wdata      = (c == 0) ? bus.left_channel_data    : bus.right_channel_data;
    assign wen        = (c == 0) ? bus.left_channel_data_en : bus.right_channel_data_en;
    assign do_wr      = wen && !full;
    assign used       = full ? 8'd128 : {1'b0, wr_ptr - rd_ptr};
    assign empty[c]   = !full && (wr_ptr == rd_ptr);
    assign rd_data[c] = mem[rd_ptr];
    assign space[c]   = space_q;

    always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr  <= 7'd0;
        rd_ptr  <= 7'd0;
        full    <= 1'b0;
        space_q <= 8'd128;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + 7'd1;
        if (pop)   rd_ptr <= rd_ptr + 7'd1;
        if (do_wr && !pop && ((wr_ptr + 7'd1) == rd_ptr)) full <= 1'b1;
        else if (pop && !do_wr)                            full <= 1'b0;
        space_q <= 8'd128 - used;
      end
    end
  end

  assign bus.left_channel_fifo_write_space  = space[0];
  assign bus.right_channel_fifo_write_space = space[1];
  assign bus.serial_audio_out_data          = serial_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= WAIT_SYNC;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    clear      = 1'b0;
    load_frame = 1'b0;
    load_hold  = 1'b0;
    shift_step = 1'b0;
    if (!bus.enable_audio_output) begin
      state_next = WAIT_SYNC;
      clear      = 1'b1;
    end else if (bus.left_right_clk_rising_edge) begin
      state_next = LEFT;
      load_frame = 1'b1;
    end else if (state != WAIT_SYNC) begin
      if (bus.left_right_clk_falling_edge) begin
        state_next = RIGHT;
        load_hold  = 1'b1;
      end else begin
        shift_step = bus.bit_clk_falling_edge;
      end
    end
  end

  // An LR edge takes priority over a coincident bit strobe: load now, shift later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      hold_reg   <= '0;
      bit_cnt    <= 5'd0;
      bit_active <= 1'b0;
      serial_out <= 1'b0;
    end else if (clear) begin
      shift_reg  <= '0;
      hold_reg   <= '0;
      bit_cnt    <= 5'd0;
      bit_active <= 1'b0;
      serial_out <= 1'b0;
    end else if (load_frame) begin
      shift_reg  <= pop ? rd_data[0] : '0;
      hold_reg   <= pop ? rd_data[1] : '0;
      bit_cnt    <= BIT_COUNTER_INIT;
      bit_active <= 1'b1;
    end else if (load_hold) begin
      shift_reg  <= hold_reg;
      bit_cnt    <= BIT_COUNTER_INIT;
      bit_active <= 1'b1;
    end else if (shift_step) begin
      if (bit_active) begin
        serial_out <= shift_reg[AUDIO_DATA_WIDTH];
        shift_reg  <= shift_reg << 1;
        if (bit_cnt == 5'd0) bit_active <= 1'b0;
        else                 bit_cnt    <= bit_cnt - 5'd1;
      end else begin
        serial_out <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/audio_out_serializer.md
AUDIO_OUT_SERIALIZER -- requirements
Module: audio_out_serializer

Interface
REQ-001 SHALL have parameter AUDIO_DATA_WIDTH, default 32, meaning bits per channel sample; valid range 1..32.
REQ-002 SHALL have parameter BIT_COUNTER_INIT, default 5'd31, meaning bit index of the first bit sent per frame (AUDIO_DATA_WIDTH-1).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have ports bit_clk_rising_edge and bit_clk_falling_edge, input, 1 each, one-clk strobes for the codec bit clock.
REQ-006 SHALL have ports left_right_clk_rising_edge and left_right_clk_falling_edge, input, 1 each, one-clk strobes for the frame clock.
REQ-007 SHALL have port enable_audio_output, input, 1, allows serialization when high.
REQ-008 SHALL have ports left_channel_data and right_channel_data, input, [AUDIO_DATA_WIDTH:1], sample words to queue.
REQ-009 SHALL have ports left_channel_data_en and right_channel_data_en, input, 1 each, one-clk write strobes.
REQ-010 SHALL have ports left_channel_fifo_write_space and right_channel_fifo_write_space, output, 8 each, free FIFO words (0..128), registered.
REQ-011 SHALL have port serial_audio_out_data, output, 1, registered serial data to the codec.

Function
REQ-012 SHALL contain one 128-word FIFO per channel, 7-bit pointers, plus a full flag.
REQ-013 SHALL write a word when data_en=1 and that FIFO is not full; a write to a full FIFO SHALL be dropped with no state change.
REQ-014 SHALL update write_space one clk after any FIFO change, value = 128 - words_used; full gives 0, empty gives 128.
REQ-015 SHALL apply a simultaneous write and pop on one FIFO in the same clk, leaving the count unchanged.
REQ-016 SHALL run an FSM with three states: WAIT_SYNC, LEFT, RIGHT.
REQ-017 SHALL hold WAIT_SYNC while enable_audio_output=0 and on the first LR rising edge with enable=1 go to LEFT.
REQ-018 SHALL go LEFT->RIGHT on LR falling edge and RIGHT->LEFT on LR rising edge.
REQ-019 SHALL, at each LR rising edge with enable=1, pop both FIFOs only if both are non-empty, load the left word into the shift register and hold the right word in a holding register.
REQ-020 SHALL, if either FIFO is empty at that point (underflow), pop neither, load zero into both the shift register and the holding register, and send silence for that full frame.
REQ-021 SHALL load the holding register into the shift register at the LR falling edge.
REQ-022 SHALL reset the bit counter to BIT_COUNTER_INIT at every LR edge.
REQ-023 SHALL, on each bit_clk_falling_edge while the counter is active, drive serial_audio_out_data with the shift register MSB, shift left by one with zero fill, and decrement the counter.
REQ-024 SHALL stop the counter after AUDIO_DATA_WIDTH bits and drive 0 on later bit clock falling edges until the next LR edge.
REQ-025 SHALL, when an LR edge and bit_clk_falling_edge occur in the same clk, load the new word and not shift; the MSB then goes out on the next bit clock falling edge.
REQ-026 SHALL, when enable_audio_output falls, in the next clk go to WAIT_SYNC, clear the shift and holding registers and force the output to 0; FIFO contents are kept.
REQ-027 SHALL ignore bit clock strobes in WAIT_SYNC, with output held at 0.

Reset
REQ-028 SHALL, on reset assertion and independent of clk, empty both FIFOs, set both write_space outputs to 128 (8'h80), set serial_audio_out_data to 0, clear the shift, holding and counter registers, and put the FSM in WAIT_SYNC.
REQ-029 SHALL, when reset asserts mid-frame, abort the frame at once; the first sample after release waits for a new LR rising edge.

Verification
REQ-030 Write left 32'hA5000001 and right 32'h5A000002, enable=1, run LR/bit clock -> serial stream is 1010_0101_0...01 during LR high and 0101_1010_0...10 during LR low; write_space returns to 128.
REQ-031 Write 128 words to left with no reads, then one more -> write_space 0, the 129th word dropped, first-in word sent first.
REQ-032 Left holds 2 words, right is empty, at LR rising edge -> no pop, output all zeros, left write_space stays 126.
REQ-033 LR rising edge coincides with bit_clk_falling_edge -> output changes to the MSB on the next bit falling edge, not the same clk.
REQ-034 Drop enable mid-left-frame -> output 0 within 1 clk, FSM in WAIT_SYNC; on re-enable, the stream resumes at the next LR rising edge with the next queued pair.
REQ-035 Assert reset asynchronously mid-frame with 5 words queued -> output 0 and write_space 128 before the next clk edge.
